// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Operand forwarding and load-use hazard unit, placed beside the ID/EX register.
//   Forwarding selects are combinational. Load-use stalls last LOAD_LAT cycles.
//   Stalls of more than one cycle are sequenced by a small IDLE/STALL FSM.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   id_rs, id_rt             IF/ID source registers (load-use detection)
//   ex_rs, ex_rt             ID/EX source registers (forwarding)
//   ex_rd, ex_memread        ID/EX destination register and load flag
//   stg_rd, stg_regwrite     per-stage destination/RegWrite; stage k is slice k-1
//   flush                    branch/jump flush, aborts a stall in progress
//   fwd_a, fwd_b             operand source: 0 = register file, k = stage k
//   stall, idex_bubble       front-end freeze / ID/EX control zeroing
//   pc_write, ifid_write     inverse of stall
//   stall_cnt, fwd_cnt       event counters, only when HAZ_STATS_EN is defined
//
// Build option: define HAZ_STATS_EN to add the saturating stall/forward counters.

module hazard_forward_unit #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned N_STAGES = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REG_AW-1:0]            id_rs,
    input  logic [REG_AW-1:0]            id_rt,
    input  logic [REG_AW-1:0]            ex_rs,
    input  logic [REG_AW-1:0]            ex_rt,
    input  logic [REG_AW-1:0]            ex_rd,
    input  logic                         ex_memread,
    input  logic [N_STAGES*REG_AW-1:0]   stg_rd,
    input  logic [N_STAGES-1:0]          stg_regwrite,
    input  logic                         flush,
    output logic [SEL_W-1:0]             fwd_a,
    output logic [SEL_W-1:0]             fwd_b,
    output logic                         stall,
    output logic                         pc_write,
    output logic                         ifid_write,
    output logic                         idex_bubble
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0]                  stall_cnt,
    output logic [31:0]                  fwd_cnt
`endif
);

    localparam logic [3:0] LAT_M1    = 4'(LOAD_LAT - 1);
    localparam bit         MULTI_CYC = (LOAD_LAT > 1);

    typedef enum logic {IDLE, STALL} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [SEL_W-1:0] fwd_a_c, fwd_b_c;
    logic             detect_c;
    logic             stall_c;

    // Forward select: scan furthest to nearest so the nearest matching stage wins.
    always_comb begin
        fwd_a_c = '0;
        fwd_b_c = '0;
        for (int unsigned i = 0; i < N_STAGES; i++) begin
            int unsigned      idx;
            logic [REG_AW-1:0] rd;
            idx = N_STAGES - 1 - i;
            rd  = stg_rd[idx*REG_AW +: REG_AW];
            if (stg_regwrite[idx] && (rd != '0) && (rd == ex_rs)) begin
                fwd_a_c = SEL_W'(idx + 1);
            end
            if (stg_regwrite[idx] && (rd != '0) && (rd == ex_rt)) begin
                fwd_b_c = SEL_W'(idx + 1);
            end
        end
    end

    // Load-use: the instruction in ID reads the register the load in EX writes.
    assign detect_c = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));

    // Next state; the FSM is only entered when more than one stall cycle is needed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (detect_c && !flush && MULTI_CYC) begin
                    state_d = STALL;
                    cnt_d   = LAT_M1;
                end
            end
            STALL: begin
                cnt_d = cnt_q - 4'd1;
                if (flush || (cnt_q == 4'd1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stall starts in the detection cycle; reset forces every output to its idle value.
    assign stall_c = !rst && (((state_q == IDLE) && detect_c && !flush) ||
                              ((state_q == STALL) && !flush));

    assign stall       = stall_c;
    assign idex_bubble = stall_c;
    assign pc_write    = !stall_c;
    assign ifid_write  = !stall_c;
    assign fwd_a       = rst ? '0 : fwd_a_c;
    assign fwd_b       = rst ? '0 : fwd_b_c;

`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (((fwd_a != '0) || (fwd_b != '0)) && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: two instances (LOAD_LAT = 1 and 3) share stimulus.
// Expected outputs are queued when a step is driven and checked on the falling edge.

module tb_hazard_forward_unit;

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned N_STAGES = 2;
    localparam int unsigned SEL_W    = 2;

    logic                       clk;
    logic                       rst;
    logic [REG_AW-1:0]          id_rs, id_rt, ex_rs, ex_rt, ex_rd;
    logic                       ex_memread;
    logic [N_STAGES*REG_AW-1:0] stg_rd;
    logic [N_STAGES-1:0]        stg_regwrite;
    logic                       flush;

    logic [SEL_W-1:0] fa1, fb1, fa3, fb3;
    logic             st1, pw1, iw1, bb1;
    logic             st3, pw3, iw3, bb3;
`ifdef HAZ_STATS_EN
    logic [31:0]      sc1, fc1, sc3, fc3;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        string            tag;
        logic [SEL_W-1:0] fa;
        logic [SEL_W-1:0] fb;
        logic             s1;
        logic             s3;
    } exp_t;

    exp_t sb[$];

    hazard_forward_unit #(.REG_AW(REG_AW), .N_STAGES(N_STAGES), .LOAD_LAT(1), .SEL_W(SEL_W)) u_lat1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .stg_rd(stg_rd), .stg_regwrite(stg_regwrite),
        .flush(flush), .fwd_a(fa1), .fwd_b(fb1), .stall(st1), .pc_write(pw1),
        .ifid_write(iw1), .idex_bubble(bb1)
`ifdef HAZ_STATS_EN
        , .stall_cnt(sc1), .fwd_cnt(fc1)
`endif
    );

    hazard_forward_unit #(.REG_AW(REG_AW), .N_STAGES(N_STAGES), .LOAD_LAT(3), .SEL_W(SEL_W)) u_lat3 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .stg_rd(stg_rd), .stg_regwrite(stg_regwrite),
        .flush(flush), .fwd_a(fa3), .fwd_b(fb3), .stall(st3), .pc_write(pw3),
        .ifid_write(iw3), .idex_bubble(bb3)
`ifdef HAZ_STATS_EN
        , .stall_cnt(sc3), .fwd_cnt(fc3)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Pop the oldest expectation and compare every output of both instances.
    task automatic check_outputs();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".fwd_a1"}, 32'(fa1), 32'(e.fa));
        chk({e.tag, ".fwd_b1"}, 32'(fb1), 32'(e.fb));
        chk({e.tag, ".fwd_a3"}, 32'(fa3), 32'(e.fa));
        chk({e.tag, ".fwd_b3"}, 32'(fb3), 32'(e.fb));
        chk({e.tag, ".stall1"}, 32'(st1), 32'(e.s1));
        chk({e.tag, ".stall3"}, 32'(st3), 32'(e.s3));
        chk({e.tag, ".pc_write1"}, 32'(pw1), 32'(!e.s1));
        chk({e.tag, ".pc_write3"}, 32'(pw3), 32'(!e.s3));
        chk({e.tag, ".ifid_write1"}, 32'(iw1), 32'(!e.s1));
        chk({e.tag, ".ifid_write3"}, 32'(iw3), 32'(!e.s3));
        chk({e.tag, ".bubble1"}, 32'(bb1), 32'(e.s1));
        chk({e.tag, ".bubble3"}, 32'(bb3), 32'(e.s3));
    endtask

    // Queue the expectation for the current inputs, check mid-cycle, advance one edge.
    task automatic step(input string tag, input logic [SEL_W-1:0] fa, input logic [SEL_W-1:0] fb,
                        input logic s1, input logic s3);
        exp_t e;
        e.tag = tag; e.fa = fa; e.fb = fb; e.s1 = s1; e.s3 = s3;
        sb.push_back(e);
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with inputs that would otherwise forward and stall.
        rst = 1'b1; flush = 1'b0;
        stg_regwrite = 2'b11; stg_rd = {5'd3, 5'd3};
        ex_rs = 5'd3; ex_rt = 5'd0;
        ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd0; id_rt = 5'd8;
        step("reset0", 2'd0, 2'd0, 1'b0, 1'b0);
        step("reset1", 2'd0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0; ex_memread = 1'b0;

        // Forwarding priority and register-0 rule.
        step("fwd_nearest", 2'd1, 2'd0, 1'b0, 1'b0);
        stg_regwrite = 2'b10;
        step("fwd_stage2", 2'd2, 2'd0, 1'b0, 1'b0);
        stg_regwrite = 2'b01; ex_rt = 5'd3;
        step("fwd_both_s1", 2'd1, 2'd1, 1'b0, 1'b0);
        stg_regwrite = 2'b11; stg_rd = '0; ex_rs = 5'd0; ex_rt = 5'd0;
        step("fwd_reg0", 2'd0, 2'd0, 1'b0, 1'b0);
        stg_rd = {5'd7, 5'd5}; ex_rs = 5'd7; ex_rt = 5'd5;
        step("fwd_mixed", 2'd2, 2'd1, 1'b0, 1'b0);
        ex_rs = 5'd9; ex_rt = 5'd5;
        step("fwd_nomatch", 2'd0, 2'd1, 1'b0, 1'b0);
        stg_regwrite = 2'b00;
        step("fwd_noregwrite", 2'd0, 2'd0, 1'b0, 1'b0);

        // Single-cycle detect: 1 stall on LOAD_LAT=1, 3 on LOAD_LAT=3.
        ex_memread = 1'b1; ex_rd = 5'd8; id_rt = 5'd8; id_rs = 5'd0;
        step("lu_c1", 2'd0, 2'd0, 1'b1, 1'b1);
        ex_memread = 1'b0;
        step("lu_c2", 2'd0, 2'd0, 1'b0, 1'b1);
        step("lu_c3", 2'd0, 2'd0, 1'b0, 1'b1);
        step("lu_c4", 2'd0, 2'd0, 1'b0, 1'b0);

        // Flush in the second stall cycle, then flush in the detect cycle.
        ex_memread = 1'b1;
        step("fl_c1", 2'd0, 2'd0, 1'b1, 1'b1);
        ex_memread = 1'b0; flush = 1'b1;
        step("fl_c2", 2'd0, 2'd0, 1'b0, 1'b0);
        flush = 1'b0;
        step("fl_c3", 2'd0, 2'd0, 1'b0, 1'b0);
        ex_memread = 1'b1; flush = 1'b1;
        step("fl_detect", 2'd0, 2'd0, 1'b0, 1'b0);
        ex_memread = 1'b0; flush = 1'b0;
        step("fl_after", 2'd0, 2'd0, 1'b0, 1'b0);

        // Held detect: ignored in STALL, re-detected in the first IDLE cycle.
        ex_memread = 1'b1;
        step("b2b_c1", 2'd0, 2'd0, 1'b1, 1'b1);
        step("b2b_c2", 2'd0, 2'd0, 1'b1, 1'b1);
        step("b2b_c3", 2'd0, 2'd0, 1'b1, 1'b1);
        step("b2b_c4", 2'd0, 2'd0, 1'b1, 1'b1);
        ex_memread = 1'b0;
        step("b2b_c5", 2'd0, 2'd0, 1'b0, 1'b1);
        step("b2b_c6", 2'd0, 2'd0, 1'b0, 1'b1);
        step("b2b_c7", 2'd0, 2'd0, 1'b0, 1'b0);

        // Detect through id_rs, then reset in the middle of the stall.
        ex_memread = 1'b1; id_rs = 5'd8; id_rt = 5'd0;
        step("rs_c1", 2'd0, 2'd0, 1'b1, 1'b1);
        ex_memread = 1'b0;
        step("rs_c2", 2'd0, 2'd0, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
`ifdef HAZ_STATS_EN
        chk("stats_rst_stall_cnt", sc3, 32'd0);
        chk("stats_rst_fwd_cnt", fc3, 32'd0);
`endif
        step("rst_mid_stall", 2'd0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step("rst_idle", 2'd0, 2'd0, 1'b0, 1'b0);

        // ex_rd = 0 is never a hazard even if a source is also 0.
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        step("lu_rd0", 2'd0, 2'd0, 1'b0, 1'b0);
        ex_memread = 1'b0;

        // Five forwarding cycles, then two stall cycles on LOAD_LAT=1.
        stg_regwrite = 2'b01; stg_rd = {5'd0, 5'd3}; ex_rs = 5'd3; ex_rt = 5'd0;
        for (int i = 0; i < 5; i++) begin
            step("fwd_run", 2'd1, 2'd0, 1'b0, 1'b0);
        end
        stg_regwrite = 2'b00; ex_memread = 1'b1; ex_rd = 5'd8; id_rt = 5'd8;
        step("st_run1", 2'd0, 2'd0, 1'b1, 1'b1);
        step("st_run2", 2'd0, 2'd0, 1'b1, 1'b1);
        ex_memread = 1'b0;
`ifdef HAZ_STATS_EN
        chk("stats_fwd_cnt", fc1, 32'd5);
        chk("stats_stall_cnt", sc1, 32'd2);
        chk("stats_stall_cnt3", sc3, 32'd2);
`endif
        step("st_tail1", 2'd0, 2'd0, 1'b0, 1'b1);
        step("st_tail2", 2'd0, 2'd0, 1'b0, 1'b0);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
